// File: rtl/alu_pkg.sv
// Shared funct codes and state encoding for the result stage.
// The MTHI/MTLO codes are only decoded when MTHILO_EN is defined.
package alu_pkg;

   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CNT_W   = 6;

   localparam logic [FUNCT_W-1:0] FN_AND   = 6'd36;
   localparam logic [FUNCT_W-1:0] FN_OR    = 6'd37;
   localparam logic [FUNCT_W-1:0] FN_ADD   = 6'd32;
   localparam logic [FUNCT_W-1:0] FN_SUB   = 6'd34;
   localparam logic [FUNCT_W-1:0] FN_SLT   = 6'd42;
   localparam logic [FUNCT_W-1:0] FN_SRL   = 6'd2;
   localparam logic [FUNCT_W-1:0] FN_MULTU = 6'd25;
   localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'd16;
   localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'd18;
   localparam logic [FUNCT_W-1:0] FN_MTHI  = 6'd17;
   localparam logic [FUNCT_W-1:0] FN_MTLO  = 6'd19;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MUL_WAIT = 1'b1
   } state_e;

   // Codes whose result comes straight from the ALU.
   function automatic logic is_alu_op(input logic [FUNCT_W-1:0] fn);
      return (fn == FN_AND) || (fn == FN_OR) || (fn == FN_ADD) ||
             (fn == FN_SUB) || (fn == FN_SLT);
   endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair with independent write enables and a shared 64-bit load port.
module hilo_reg
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              hi_we,
   input  logic              lo_we,
   input  logic [63:0]       load_data,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (hi_we) hi_d = load_data[63:32];
      if (lo_we) lo_d = load_data[31:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/alu_result_hilo.sv
// Result stage: registers ALU/shifter/HI/LO results and sequences MULTU.
// Define MTHILO_EN to enable the MTHI/MTLO writes into HI/LO.
module alu_result_hilo
   import alu_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 32
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FUNCT_W-1:0] Signal,
   input  logic [DATA_W-1:0]  dataA,
   input  logic [DATA_W-1:0]  alu_out,
   input  logic [DATA_W-1:0]  shift_out,
   input  logic [63:0]        mul_product,
   output logic               mul_start,
   output logic               mul_done,
   output logic               out_valid,
   output logic [DATA_W-1:0]  dataOut
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              out_valid_q, out_valid_d;
   logic              mul_start_q, mul_start_d;
   logic              mul_done_q, mul_done_d;
   logic              in_ready_q, in_ready_d;

   logic              accept;
   logic              hi_we, lo_we;
   logic [63:0]       load_data;
   logic [DATA_W-1:0] hi, lo;

`ifndef MTHILO_EN
   logic unused_data_a;
   assign unused_data_a = ^dataA;
`endif

   hilo_reg u_hilo_reg (
      .clk       (clk),
      .reset     (reset),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .load_data (load_data),
      .hi        (hi),
      .lo        (lo)
   );

   assign accept = in_valid & in_ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      mul_start_d = 1'b0;
      mul_done_d  = 1'b0;
      hi_we       = 1'b0;
      lo_we       = 1'b0;
      load_data   = mul_product;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_alu_op(Signal)) begin
                  data_out_d  = alu_out;
                  out_valid_d = 1'b1;
               end else begin
                  case (Signal)
                     FN_SRL: begin
                        data_out_d  = shift_out;
                        out_valid_d = 1'b1;
                     end
                     FN_MFHI: begin
                        data_out_d  = hi;
                        out_valid_d = 1'b1;
                     end
                     FN_MFLO: begin
                        data_out_d  = lo;
                        out_valid_d = 1'b1;
                     end
                     FN_MULTU: begin
                        state_d     = ST_MUL_WAIT;
                        cnt_d       = '0;
                        mul_start_d = 1'b1;
                     end
`ifdef MTHILO_EN
                     FN_MTHI: begin
                        hi_we     = 1'b1;
                        load_data = {dataA, {DATA_W{1'b0}}};
                     end
                     FN_MTLO: begin
                        lo_we     = 1'b1;
                        load_data = {{DATA_W{1'b0}}, dataA};
                     end
`endif
                     default: begin
                        data_out_d  = '0;
                        out_valid_d = 1'b1;
                     end
                  endcase
               end
            end
         end
         ST_MUL_WAIT: begin
            // Operations offered while busy are dropped: in_ready is low.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               hi_we      = 1'b1;
               lo_we      = 1'b1;
               mul_done_d = 1'b1;
               state_d    = ST_IDLE;
               cnt_d      = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         mul_start_q <= 1'b0;
         mul_done_q  <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         mul_start_q <= mul_start_d;
         mul_done_q  <= mul_done_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mul_start = mul_start_q;
   assign mul_done  = mul_done_q;
   assign out_valid = out_valid_q;
   assign dataOut   = data_out_q;

endmodule

// File: tb/tb_alu_result_hilo.sv
// Directed bench for alu_result_hilo: ALU/SRL/unknown codes, MULTU handshake, busy drop, reset.
module tb_alu_result_hilo;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  Signal;
   logic [31:0] dataA;
   logic [31:0] alu_out;
   logic [31:0] shift_out;
   logic [63:0] mul_product;
   logic        mul_start;
   logic        mul_done;
   logic        out_valid;
   logic [31:0] dataOut;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_dout;

   always #5 clk = ~clk;

   alu_result_hilo #(.MUL_CYCLES(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Signal      (Signal),
      .dataA       (dataA),
      .alu_out     (alu_out),
      .shift_out   (shift_out),
      .mul_product (mul_product),
      .mul_start   (mul_start),
      .mul_done    (mul_done),
      .out_valid   (out_valid),
      .dataOut     (dataOut)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one operation for a single edge, then samples the result.
   task automatic issue(input logic [5:0] fn);
      Signal   = fn;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int busy, starts, dones, guard;

      reset = 1'b1; in_valid = 1'b0; Signal = '0; dataA = '0;
      alu_out = '0; shift_out = '0; mul_product = '0;
      tick(); tick();
      reset = 1'b0;

      check("rst_dout",      dataOut,   0);
      check("rst_out_valid", out_valid, 0);
      check("rst_mul_start", mul_start, 0);
      check("rst_mul_done",  mul_done,  0);
      check("rst_in_ready",  in_ready,  1);
      issue(6'd16);
      check("rst_mfhi", dataOut, 32'h0);

      shift_out = 32'h0000_00F0;
      issue(6'd2);
      check("srl_valid", out_valid, 1);
      check("srl_dout",  dataOut,   32'h0000_00F0);
      tick();
      check("srl_hold_valid", out_valid, 0);
      check("srl_hold_dout",  dataOut,   32'h0000_00F0);

      alu_out = 32'hA5A5_0F0F;
      issue(6'd36);
      check("and_dout", dataOut, 32'hA5A5_0F0F);
      alu_out = 32'h0000_0001;
      issue(6'd42);
      check("slt_dout",  dataOut,   32'h0000_0001);
      check("slt_valid", out_valid, 1);

      issue(6'h3F);
      check("unk_valid", out_valid, 1);
      check("unk_dout",  dataOut,   0);

      dataA = 32'hCAFE_0001;
      issue(6'd17);
`ifdef MTHILO_EN
      check("mthi_valid", out_valid, 0);
      issue(6'd16);
      check("mthi_mfhi", dataOut, 32'hCAFE_0001);
      exp_dout = 32'hCAFE_0001;
`else
      check("code17_valid", out_valid, 1);
      check("code17_dout",  dataOut,   0);
      exp_dout = 32'h0;
`endif

      mul_product = 64'h0000_0001_FFFF_FFFE;
      issue(6'd25);
      check("multu_no_valid", out_valid, 0);
      busy = 0; starts = 0; dones = 0; guard = 0;
      while (in_ready === 1'b0 && guard < 100) begin
         busy++;
         starts += int'(mul_start);
         dones  += int'(mul_done);
         guard++;
         if (busy == 5) begin
            alu_out = 32'h0000_1234;
            issue(6'd32);
            check("drop_valid", out_valid, 0);
            check("drop_dout",  dataOut,   exp_dout);
         end else begin
            tick();
         end
      end
      check("mul_busy_cycles", busy,   32);
      check("mul_start_count", starts, 1);
      check("mul_done_early",  dones,  0);
      check("mul_done_pulse",  mul_done, 1);
      issue(6'd16);
      check("mfhi_after_mul", dataOut,  32'h0000_0001);
      check("mul_done_once",  mul_done, 0);
      issue(6'd18);
      check("mflo_after_mul", dataOut,  32'hFFFF_FFFE);
      issue(6'd32);
      check("add_reissue", dataOut, 32'h0000_1234);

      mul_product = 64'h1111_2222_3333_4444;
      issue(6'd25);
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rmid_in_ready",  in_ready,  1);
      check("rmid_mul_start", mul_start, 0);
      check("rmid_mul_done",  mul_done,  0);
      check("rmid_dout",      dataOut,   0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         dones += int'(mul_done);
         tick();
      end
      check("rmid_no_done", dones, 0);
      issue(6'd16);
      check("rmid_mfhi", dataOut, 0);
      issue(6'd18);
      check("rmid_mflo", dataOut, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
